// File: rtl/out_port_hex_display.sv
// Round-robin converter of three output ports to two-digit seven-segment pairs.
// Fixed 27-cycle sweep (9 per port); registered outputs; no backpressure.
module out_port_hex_display #(
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] out_port0,
  input  logic [31:0] out_port1,
  input  logic [31:0] out_port2,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        frame
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {LOAD, SHIFT, WRITE} state_t;

  state_t      state;
  logic [1:0]  port_idx;
  logic [2:0]  shift_cnt;
  logic [31:0] hold;
  logic [7:0]  bcd;
  logic [6:0]  bin;

  logic [31:0] sel;
  logic [7:0]  bcd_adj;
  logic        ovf;
  logic [6:0]  tens_seg;
  logic [6:0]  ones_seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    case (port_idx)
      2'd0:    sel = out_port0;
      2'd1:    sel = out_port1;
      default: sel = out_port2;
    endcase
  end

  always_comb begin
    bcd_adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    bcd_adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
  end

  // Overflow is judged on the full held value; the BCD result is then ignored.
  always_comb begin
    ovf      = (hold > 32'd99);
    ones_seg = ovf ? SEG_DASH : seg7(bcd[3:0]);
    if (ovf)
      tens_seg = SEG_DASH;
    else if (BLANK_LEADING && (bcd[7:4] == 4'd0))
      tens_seg = SEG_BLANK;
    else
      tens_seg = seg7(bcd[7:4]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= LOAD;
      port_idx  <= 2'd0;
      shift_cnt <= 3'd0;
      hold      <= 32'd0;
      bcd       <= 8'd0;
      bin       <= 7'd0;
      hex0      <= SEG_BLANK;
      hex1      <= SEG_BLANK;
      hex2      <= SEG_BLANK;
      hex3      <= SEG_BLANK;
      hex4      <= SEG_BLANK;
      hex5      <= SEG_BLANK;
      frame     <= 1'b0;
    end else begin
      frame <= 1'b0;
      case (state)
        LOAD: begin
          hold      <= sel;
          bcd       <= 8'd0;
          bin       <= sel[6:0];
          shift_cnt <= 3'd0;
          state     <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[6:0], bin, 1'b0};
          shift_cnt  <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd6)
            state <= WRITE;
        end
        WRITE: begin
          case (port_idx)
            2'd0:    begin hex1 <= tens_seg; hex0 <= ones_seg; end
            2'd1:    begin hex3 <= tens_seg; hex2 <= ones_seg; end
            default: begin hex5 <= tens_seg; hex4 <= ones_seg; end
          endcase
          frame    <= (port_idx == 2'd2);
          port_idx <= (port_idx == 2'd2) ? 2'd0 : port_idx + 2'd1;
          state    <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
